// File: rtl/rect_pkg.sv
// Shared types for the rectangle position controller.
//   XW / CW    : coordinate and colour widths
//   state_t    : controller FSM states
//   rect_cfg   : {x, y, color} bundle, used for shadow and active registers
//   clamp_coord: saturate a coordinate at an upper limit
package rect_pkg;

    localparam int XW = 11;
    localparam int CW = 12;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [CW-1:0] color;
    } rect_cfg;

    function automatic logic [XW-1:0] clamp_coord(input logic [XW-1:0] v,
                                                  input logic [XW-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rect_pos_ctl_rr_arb.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   mask    : requesters excluded this cycle
//   ptr     : highest-priority index
//   gnt     : one-hot grant (zero if nothing eligible)
//   gnt_idx : index of the granted requester (0 when no grant)
module rr_arb #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gnt_idx
);

    logic [N_REQ-1:0] elig;
    logic             found;

    assign elig = req & ~mask;

    // Two passes give the wrap-around search: first indices at or above
    // the pointer, then the ones below it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i] && (PW'(i) >= ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i] && (PW'(i) < ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/rect_pos_ctl.sv
// Frame-synchronous position/colour controller for the rectangle overlay.
// Requesters are arbitrated round-robin into a shadow register; the shadow
// is committed to the active outputs on the rising edge of vertical blank.
//   clk, rst_n          : pixel clock, async active-low reset
//   vblnk_in            : vertical blank from the timing chain
//   req/req_x/req_y/req_color : packed per-requester update requests
//   ack                 : one-cycle accept pulse per requester
//   x_pos/y_pos/color   : active rectangle to the overlay stage
//   pending             : shadow holds an uncommitted update
//   frame_tick          : one-cycle pulse on each commit
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | shadow empty, nothing to commit
// PEND  | shadow valid, committed at next vblank rise
module rect_pos_ctl
    import rect_pkg::*;
#(
    parameter int          N_REQ      = 2,
    parameter int          MAX_X      = 800,
    parameter int          MAX_Y      = 600,
    parameter int          WIDTH      = 64,
    parameter int          HEIGHT     = 64,
    parameter int          INIT_X     = 0,
    parameter int          INIT_Y     = 0,
    parameter logic [11:0] INIT_COLOR = 12'hf_0_0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vblnk_in,
    input  logic [N_REQ-1:0]    req,
    input  logic [11*N_REQ-1:0] req_x,
    input  logic [11*N_REQ-1:0] req_y,
    input  logic [12*N_REQ-1:0] req_color,
    output logic [N_REQ-1:0]    ack,
    output logic [10:0]         x_pos,
    output logic [10:0]         y_pos,
    output logic [11:0]         color,
    output logic                pending,
    output logic                frame_tick
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [XW-1:0] X_LIM = XW'(MAX_X - WIDTH);
    localparam logic [XW-1:0] Y_LIM = XW'(MAX_Y - HEIGHT);
    localparam rect_cfg INIT_CFG = '{x: XW'(INIT_X), y: XW'(INIT_Y), color: INIT_COLOR};

    state_t           state;
    rect_cfg          shadow;
    rect_cfg          active;
    rect_cfg          sel;
    logic [PW-1:0]    ptr;
    logic             vblnk_d;
    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_idx;
    logic             any_gnt;
    logic             commit;

    // Previous grantee is masked so a req still high during its ack cycle
    // is not accepted twice.
    rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req     (req),
        .mask    (ack),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt = |gnt;
    assign commit  = vblnk_in && !vblnk_d && (state == PEND);

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel.x     = clamp_coord(req_x[i*XW +: XW], X_LIM);
                sel.y     = clamp_coord(req_y[i*XW +: XW], Y_LIM);
                sel.color = req_color[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= INIT_CFG;
            ptr        <= '0;
            vblnk_d    <= 1'b0;
            ack        <= '0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vblnk_in;
            ack        <= gnt;
            frame_tick <= commit;

            if (commit)
                active <= shadow;

            // A grant in the commit cycle refills the shadow after the old
            // contents have been taken, so the FSM stays in PEND.
            if (any_gnt) begin
                shadow <= sel;
                ptr    <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            end

            case (state)
                IDLE: if (any_gnt) state <= PEND;
                PEND: if (commit && !any_gnt) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign pending = (state == PEND);
    assign x_pos   = active.x;
    assign y_pos   = active.y;
    assign color   = active.color;

endmodule

// File: tb/tb_rect_pos_ctl.sv
module tb_rect_pos_ctl;

    logic        clk;
    logic        rst_n;
    logic        vblnk_in;
    logic [1:0]  req;
    logic [21:0] req_x;
    logic [21:0] req_y;
    logic [23:0] req_color;
    logic [1:0]  ack;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic [11:0] color;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    rect_pos_ctl #(
        .N_REQ(2), .MAX_X(800), .MAX_Y(600), .WIDTH(64), .HEIGHT(64),
        .INIT_X(100), .INIT_Y(50), .INIT_COLOR(12'hf00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk_in   (vblnk_in),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .ack        (ack),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .color      (color),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [10:0] x, input logic [10:0] y,
                           input logic [11:0] c);
        req_x[i*11 +: 11]     = x;
        req_y[i*11 +: 11]     = y;
        req_color[i*12 +: 12] = c;
    endtask

    task automatic chk_out(input string tag, input logic [10:0] x, input logic [10:0] y,
                           input logic [11:0] c);
        chk({tag, ".x"}, 32'(x_pos), 32'(x));
        chk({tag, ".y"}, 32'(y_pos), 32'(y));
        chk({tag, ".color"}, 32'(color), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0; vblnk_in = 1'b0; req = '0;
        req_x = '0; req_y = '0; req_color = '0;
        repeat (3) tick();

        // Reset state
        chk_out("reset", 11'd100, 11'd50, 12'hf00);
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.ack", 32'(ack), 32'd0);
        chk("reset.tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request then vblank commit
        set_req(0, 11'd200, 11'd300, 12'h0f0);
        req = 2'b01;
        tick();
        chk("single.ack", 32'(ack), 32'b01);
        chk("single.pending", 32'(pending), 32'd1);
        chk("single.x_hold", 32'(x_pos), 32'd100);
        req = 2'b00;
        tick();
        chk("single.ack_off", 32'(ack), 32'd0);
        chk("single.x_hold2", 32'(x_pos), 32'd100);
        vblnk_in = 1'b1;
        tick();
        chk_out("single.commit", 11'd200, 11'd300, 12'h0f0);
        chk("single.tick", 32'(frame_tick), 32'd1);
        chk("single.pend_clr", 32'(pending), 32'd0);
        tick();
        chk("single.tick_off", 32'(frame_tick), 32'd0);
        vblnk_in = 1'b0;
        tick();

        // Pointer is 1 now; grant requester 1 alone to bring it back to 0
        set_req(1, 11'd400, 11'd100, 12'h00f);
        req = 2'b10;
        tick();
        chk("r1.ack", 32'(ack), 32'b10);
        req = 2'b00;
        tick();

        // Both held high: acks alternate 0,1,0,1
        set_req(0, 11'd10, 11'd20, 12'h111);
        set_req(1, 11'd30, 11'd40, 12'h222);
        req = 2'b11;
        tick(); chk("rr.ack1", 32'(ack), 32'b01);
        tick(); chk("rr.ack2", 32'(ack), 32'b10);
        tick(); chk("rr.ack3", 32'(ack), 32'b01);
        tick(); chk("rr.ack4", 32'(ack), 32'b10);
        req = 2'b00;
        tick();
        chk("rr.ack_off", 32'(ack), 32'd0);
        chk("rr.pending", 32'(pending), 32'd1);
        vblnk_in = 1'b1;
        tick();
        chk_out("rr.commit", 11'd30, 11'd40, 12'h222);
        chk("rr.tick", 32'(frame_tick), 32'd1);
        vblnk_in = 1'b0;
        tick();

        // Clamping at the right/bottom edges (pointer back at 0)
        set_req(0, 11'd790, 11'd599, 12'habc);
        req = 2'b01;
        tick();
        chk("clamp.ack", 32'(ack), 32'b01);
        req = 2'b00;
        vblnk_in = 1'b1;
        tick();
        chk_out("clamp.commit", 11'd736, 11'd536, 12'habc);
        vblnk_in = 1'b0;
        tick();

        // Exact limit passes through unchanged; requester 1 (pointer is 1)
        set_req(1, 11'd736, 11'd535, 12'h0aa);
        req = 2'b10;
        tick();
        chk("limit.ack", 32'(ack), 32'b10);
        req = 2'b00;
        vblnk_in = 1'b1;
        tick();
        chk_out("limit.commit", 11'd736, 11'd535, 12'h0aa);
        vblnk_in = 1'b0;
        tick();

        // Grant and vblank edge in the same cycle (pointer at 0)
        set_req(0, 11'd5, 11'd6, 12'h123);
        req = 2'b01;
        tick();
        chk("same.ack_a", 32'(ack), 32'b01);
        req = 2'b00;
        tick();
        set_req(1, 11'd7, 11'd8, 12'h456);
        req = 2'b10;
        vblnk_in = 1'b1;
        tick();
        chk_out("same.old", 11'd5, 11'd6, 12'h123);
        chk("same.tick", 32'(frame_tick), 32'd1);
        chk("same.pending", 32'(pending), 32'd1);
        chk("same.ack_b", 32'(ack), 32'b10);
        req = 2'b00;
        vblnk_in = 1'b0;
        tick();
        tick();
        chk("same.tick_off", 32'(frame_tick), 32'd0);
        vblnk_in = 1'b1;
        tick();
        chk_out("same.new", 11'd7, 11'd8, 12'h456);
        chk("same.tick2", 32'(frame_tick), 32'd1);
        chk("same.pend_clr", 32'(pending), 32'd0);
        vblnk_in = 1'b0;
        tick();

        // Reset while pending discards the shadow
        set_req(0, 11'd300, 11'd300, 12'h777);
        req = 2'b01;
        tick();
        chk("rst.pending_set", 32'(pending), 32'd1);
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 11'd100, 11'd50, 12'hf00);
        chk("rst.pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        vblnk_in = 1'b1;
        tick();
        chk("rst.no_tick", 32'(frame_tick), 32'd0);
        chk_out("rst.after_vb", 11'd100, 11'd50, 12'hf00);
        vblnk_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rect_pos_ctl.md
# rect_pos_ctl

Frame-synchronous position/colour controller for the runtime-positioned rectangle overlay stage of the VGA pipeline. Several requesters (keyboard, mouse, numeric-status logic) submit new rectangle coordinates and colour. The block arbitrates between them round-robin and holds the winning request in a shadow register. The shadow is committed to the overlay stage only at the start of vertical blanking, so the rectangle never tears mid-frame.

## Interface
- N_REQ, 2: number of requesters (1..8)
- MAX_X, 800: visible width in pixels
- MAX_Y, 600: visible height in lines
- WIDTH, 64: rectangle width, used for clamping
- HEIGHT, 64: rectangle height, used for clamping
- INIT_X, 0: x_pos after reset
- INIT_Y, 0: y_pos after reset
- INIT_COLOR, 12'hf_0_0: color after reset
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, asynchronous and active-low
- vblnk_in  in  1  vertical blank from the timing chain
- req  in  N_REQ  per-requester update request; level, held until acked
- req_x  in  11*N_REQ  packed x coordinates, requester i at [11i+10:11i]
- req_y  in  11*N_REQ  packed y coordinates, same packing
- req_color  in  12*N_REQ  packed colours, requester i at [12i+11:12i]
- ack  out  N_REQ  one-cycle accept pulse, one-hot or zero
- x_pos  out  11  active rectangle x, to the overlay stage
- y_pos  out  11  active rectangle y, to the overlay stage
- color  out  12  active rectangle colour, to the overlay stage
- pending  out  1  shadow holds an uncommitted update
- frame_tick  out  1  one-cycle pulse on each commit

## Operation
- Reset values:
  - x_pos = INIT_X, y_pos = INIT_Y, color = INIT_COLOR.
  - ack = 0, pending = 0, frame_tick = 0.
  - Round-robin pointer = 0, vblnk_d = 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: shadow empty.
  - PEND: shadow valid; `pending` = 1 exactly in this state.
- Arbitration runs every cycle in both states.
  - Eligible requesters: req[i]=1 and ack[i]=0 (the current grantee is masked for one cycle).
  - Grant goes to the first eligible index at or after the pointer, searching upward with wrap.
  - On a grant, the pointer becomes grant+1 mod N_REQ. With no grant, the pointer is unchanged.
- On a grant, the granted fields are clamped and written into the shadow (latest accepted request wins), and the FSM enters PEND.
  - Clamp: x = min(req_x, MAX_X-WIDTH); y = min(req_y, MAX_Y-HEIGHT).
  - Comparisons are 11-bit unsigned. Colour is passed unchanged.
- Commit event: vblnk_in=1 while vblnk_d=0 (rising edge), in state PEND.
  - Shadow is copied to x_pos/y_pos/color.
  - frame_tick pulses.
  - FSM goes to IDLE.
- A commit event in IDLE does nothing.
- Commit and grant in the same cycle:
  - The commit takes the old shadow.
  - The new request loads the shadow.
  - The FSM stays in PEND.
- rst_n asserted mid-operation: all state returns to reset values immediately and any shadowed update is discarded.

## Timing
- The request is sampled at edge t. ack[i] and the shadow update are both visible after edge t (cycle t+1).
- The requester must drop or change req by the cycle after it sees ack. A req still high in the ack cycle is ignored, because of the mask.
- A req still high one cycle later is treated as a new request.
- The vblank edge is detected combinationally at cycle t. x_pos/y_pos/color/frame_tick update after edge t, one cycle of latency.
- Outputs change at most once per frame.
- Throughput is one accepted request per cycle.
- All outputs are registered.

## Structure
- Shared package rect_pkg holds:
  - coordinate width XW=11 and colour width CW=12;
  - the FSM state enum {IDLE, PEND};
  - a `rect_cfg` struct {x, y, color}, used for both the shadow and the active registers.
- Sub-module rr_arb:
  - parameterised on N_REQ;
  - inputs: request vector, mask, pointer;
  - outputs: one-hot grant and grant index.

## Test plan
- Reset with INIT_X=100, INIT_Y=50: x_pos=100, y_pos=50, color=12'hf00, pending=0 before any request.
- req[0] with x=200, y=300, color=12'h0f0, then a vblank edge -> ack[0] pulses 1 cycle, pending=1, x_pos stays 100 until the edge. One cycle after the edge: x_pos=200, y_pos=300, color=12'h0f0, frame_tick=1 for 1 cycle, pending=0.
- req[0] and req[1] held high continuously, pointer at 0 -> acks alternate 0,1,0,1. After the next vblank edge, outputs show the last acked requester's values.
- req_x=790, req_y=599 -> committed x_pos=736, y_pos=536.
- Grant and vblank edge in the same cycle -> the old shadow is committed, pending stays 1, and the next vblank edge commits the new values.
- rst_n pulsed low while pending=1 -> outputs return to INIT values, and the following vblank edge produces no frame_tick.
